ann_layer_sequencer: RTL and testbench
======================================

# ann_layer_sequencer

Sequencer and result collector that sits directly downstream of the single neuron core. It walks that core across the M neurons of one layer: per neuron it issues one start pulse with a neuron index, then waits for the neuron's completion and stores its DW-bit result. It packs the M results into a layer vector for the next layer's value input and tracks the arg-max index for the output layer. The neuron index output selects the weight row and bias upstream.

## Interface
- DW, 8: data width of one neuron result (two's complement).
- M, 10: neurons per layer; M >= 2.
- IW, $clog2(M): width of neuron index.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- go  in  1  one-cycle request to evaluate a full layer.
- hidden_in  in  1  layer type (1 = hidden, 0 = output), captured at go acceptance.
- neuron_result  in  DW  result from neuron core.
- neuron_ready  in  1  neuron core completion strobe; result valid in the same cycle.
- neuron_start  out  1  one-cycle start pulse to neuron core.
- neuron_idx  out  IW  index of the neuron currently being evaluated.
- hidden_out  out  1  captured hidden_in, driven to the neuron core.
- busy  out  1  high from go acceptance until done.
- done  out  1  one-cycle pulse after the last result is stored.
- layer_valid  out  1  layer_vec/argmax_idx/max_val are complete and stable.
- layer_vec  out  DW*M  slot i at bits [DW*i +: DW].
- argmax_idx  out  IW  index of the largest result (signed compare).
- max_val  out  DW  value at argmax_idx.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (rst=0 at an edge): state IDLE. All outputs 0, including layer_vec, argmax_idx, max_val, neuron_idx and hidden_out. Any layer in progress is abandoned with no done pulse.
- IDLE: when go=1, capture hidden_in, set neuron_idx=0, clear layer_valid, set busy=1, go to ISSUE. If go=0, stay in IDLE.
- ISSUE: neuron_start=1 for exactly this cycle, then go to WAIT unconditionally.
- WAIT: neuron_start=0. While neuron_ready=0, stay in WAIT. When neuron_ready=1:
  - Write neuron_result into slot neuron_idx.
  - Update the max:
    - If neuron_idx=0, load max_val/argmax_idx unconditionally.
    - Otherwise update only if $signed(neuron_result) > $signed(max_val). Ties therefore keep the lowest index.
  - If neuron_idx=M-1, go to DONE. Otherwise increment neuron_idx and go to ISSUE.
- DONE: done=1 and layer_valid=1, then go to IDLE. busy clears in the same cycle done is asserted. layer_valid holds until the next go acceptance or reset.
- go is ignored whenever state ≠ IDLE, including in DONE. A go in IDLE the cycle after done starts a new layer normally.
- neuron_ready is ignored outside WAIT. This covers a stale or early strobe in ISSUE.
- Slots not yet rewritten during a new layer keep their previous values. Consumers qualify the outputs with layer_valid only.
- neuron_idx holds M-1 after done until the next go.
- No arithmetic beyond the index increment and the signed compare. The index never wraps past M-1.

## Timing
- go sampled at edge t gives neuron_start high in cycle t+1 with neuron_idx=0.
- A neuron_ready seen at edge u stores the result at u. The next neuron_start is high in cycle u+1, or done is high in cycle u+1 after the last neuron.
- If neuron k takes L_k cycles from start-high to ready-high (L_k >= 1), a layer takes 1 + Σ(1+L_k) cycles from go to done inclusive of the done cycle. With M=10 and L_k=1 for every neuron, done is high in cycle t+21.
- Outputs are registered. No combinational path from neuron_ready to neuron_start.

## Test plan
- Reset: hold rst=0 for 2 cycles with go=1 → all outputs 0, state IDLE, no neuron_start.
- Nominal, M=10, L=1, results 3,-5,7,7,2,0,-128,127,1,6 → ten neuron_start pulses with idx 0..9. layer_vec slots hold those values, argmax_idx=7, max_val=127, done exactly at t+21, hidden_out equals hidden_in captured at go.
- Ties and negatives, all results -4 → argmax_idx=0, max_val=-4 (0xFC). Results 5,9,9 in slots 0–2 with the rest smaller → argmax_idx=1.
- Variable latency L=1,4,2,… with go re-asserted mid-layer and neuron_ready pulsed during ISSUE → extra go ignored, stray ready ignored, exactly M captures, cycle count matches the formula.
- Reset mid-layer after 4 results → outputs cleared, no done. A subsequent go runs a full layer correctly.
- Back-to-back layers: go in the cycle right after done → layer_valid drops at acceptance, the second layer completes with its own argmax, and the first layer's values do not leak once layer_valid is high.

Source files
------------

// File: rtl/ann_layer_sequencer_if.sv
// ann_layer_sequencer_if: layer request, neuron core handshake and layer result bus
interface ann_layer_sequencer_if #(
   parameter int DW = 8,
   parameter int M  = 10,
   parameter int IW = $clog2(M)
);
   logic            go;
   logic            hidden_in;
   logic [DW-1:0]   neuron_result;
   logic            neuron_ready;
   logic            neuron_start;
   logic [IW-1:0]   neuron_idx;
   logic            hidden_out;
   logic            busy;
   logic            done;
   logic            layer_valid;
   logic [DW*M-1:0] layer_vec;
   logic [IW-1:0]   argmax_idx;
   logic [DW-1:0]   max_val;

   modport slave (
      input  go, hidden_in, neuron_result, neuron_ready,
      output neuron_start, neuron_idx, hidden_out, busy, done,
             layer_valid, layer_vec, argmax_idx, max_val
   );

   modport master (
      output go, hidden_in, neuron_result, neuron_ready,
      input  neuron_start, neuron_idx, hidden_out, busy, done,
             layer_valid, layer_vec, argmax_idx, max_val
   );
endinterface

// File: rtl/ann_layer_sequencer.sv
// ann_layer_sequencer: walks the neuron core over one layer, packs results and tracks the arg-max
module ann_layer_sequencer #(
   parameter int DW = 8,
   parameter int M  = 10,
   parameter int IW = $clog2(M)
) (
   input logic                clk,
   input logic                rst,
   ann_layer_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state_q;
   logic [IW-1:0]   idx_q;
   logic [IW-1:0]   idx_d;
   logic            start_q;
   logic            hidden_q;
   logic            busy_q;
   logic            done_q;
   logic            valid_q;
   logic [DW*M-1:0] vec_q;
   logic [IW-1:0]   amax_q;
   logic [DW-1:0]   max_q;

   assign idx_d = idx_q + IW'(1);

   // Sequencer FSM; every output is a register so neuron_ready never reaches neuron_start combinationally
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         start_q  <= 1'b0;
         hidden_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         vec_q    <= '0;
         amax_q   <= '0;
         max_q    <= '0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: if (bus.go) begin
               hidden_q <= bus.hidden_in;
               idx_q    <= '0;
               valid_q  <= 1'b0;
               busy_q   <= 1'b1;
               start_q  <= 1'b1;
               state_q  <= ISSUE;
            end
            ISSUE: state_q <= WAIT;
            WAIT: if (bus.neuron_ready) begin
               vec_q[DW*idx_q +: DW] <= bus.neuron_result;
               // strict compare keeps the lowest index on ties
               if (idx_q == '0 || $signed(bus.neuron_result) > $signed(max_q)) begin
                  max_q  <= bus.neuron_result;
                  amax_q <= idx_q;
               end
               if (idx_q == IW'(M-1)) begin
                  done_q  <= 1'b1;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_d;
                  start_q <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.neuron_start = start_q;
   assign bus.neuron_idx   = idx_q;
   assign bus.hidden_out   = hidden_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.layer_valid  = valid_q;
   assign bus.layer_vec    = vec_q;
   assign bus.argmax_idx   = amax_q;
   assign bus.max_val      = max_q;
endmodule

// File: tb/tb_ann_layer_sequencer.sv
// tb_ann_layer_sequencer: directed checks of layer sequencing, arg-max, timing and reset
module tb_ann_layer_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [7:0] res [10];
   int         lat [10];

   always #5 clk = ~clk;

   ann_layer_sequencer_if #(.DW(8), .M(10)) bus ();
   ann_layer_sequencer #(.DW(8), .M(10)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_start"}, bus.neuron_start, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_valid"}, bus.layer_valid, 0);
      check({tag, "_vec"}, bus.layer_vec, 0);
      check({tag, "_amax"}, bus.argmax_idx, 0);
      check({tag, "_max"}, bus.max_val, 0);
      check({tag, "_idx"}, bus.neuron_idx, 0);
      check({tag, "_hidden"}, bus.hidden_out, 0);
   endtask

   // Entered and left at a negedge; the go is driven in the current cycle.
   task automatic run_layer(input logic h, input bit stray, input int abort_at,
                            input int exp_amax, input logic [7:0] exp_max);
      int cyc;
      int exp_cyc;
      int w;
      logic [79:0] exp_vec;
      exp_cyc = 1;
      for (int i = 0; i < 10; i++) begin
         exp_cyc += 1 + lat[i];
         exp_vec[8*i +: 8] = res[i];
      end
      bus.go = 1'b1;
      bus.hidden_in = h;
      @(negedge clk);
      bus.go = 1'b0;
      bus.hidden_in = ~h;
      cyc = 1;
      check("valid_drop", bus.layer_valid, 0);
      check("busy_high", bus.busy, 1);
      check("hidden_cap", bus.hidden_out, h);
      for (int k = 0; k < 10; k++) begin
         w = 0;
         while (!bus.neuron_start && w < 50) begin
            @(negedge clk);
            cyc++;
            w++;
         end
         if (!bus.neuron_start) begin
            check("start_timeout", 0, 1);
            return;
         end
         check($sformatf("idx%0d", k), bus.neuron_idx, k);
         if (k == abort_at) return;
         if (stray) begin
            bus.neuron_ready = 1'b1;
            bus.neuron_result = 8'h7F;
            bus.go = 1'b1;
         end
         for (int j = 1; j <= lat[k]; j++) begin
            @(negedge clk);
            cyc++;
            bus.go = 1'b0;
            bus.neuron_ready = (j == lat[k]);
            bus.neuron_result = (j == lat[k]) ? res[k] : 8'h7F;
         end
         @(negedge clk);
         cyc++;
         bus.neuron_ready = 1'b0;
      end
      check("done_cycle", cyc, exp_cyc);
      check("done_pulse", bus.done, 1);
      check("busy_clear", bus.busy, 0);
      check("valid_set", bus.layer_valid, 1);
      check("no_start_in_done", bus.neuron_start, 0);
      check("layer_vec", bus.layer_vec, exp_vec);
      check("argmax_idx", bus.argmax_idx, exp_amax);
      check("max_val", bus.max_val, exp_max);
      check("idx_hold", bus.neuron_idx, 9);
      check("hidden_out", bus.hidden_out, h);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("valid_hold", bus.layer_valid, 1);
   endtask

   initial begin
      int d;
      bus.go = 1'b1;
      bus.hidden_in = 1'b1;
      bus.neuron_ready = 1'b0;
      bus.neuron_result = '0;
      repeat (2) @(negedge clk);
      check_cleared("reset");
      bus.go = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("idle_no_start", bus.neuron_start, 0);
      foreach (lat[i]) lat[i] = 1;
      res = '{8'h03, 8'hFB, 8'h07, 8'h07, 8'h02, 8'h00, 8'h80, 8'h7F, 8'h01, 8'h06};
      run_layer(1'b1, 1'b0, -1, 7, 8'h7F);
      res = '{8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC};
      run_layer(1'b0, 1'b0, -1, 0, 8'hFC);
      res = '{8'h05, 8'h09, 8'h09, 8'h01, 8'h00, 8'hFF, 8'h02, 8'h03, 8'h04, 8'h08};
      run_layer(1'b1, 1'b0, -1, 1, 8'h09);
      lat = '{1, 4, 2, 3, 1, 5, 2, 1, 3, 2};
      res = '{8'h0A, 8'h14, 8'hE2, 8'h28, 8'hCE, 8'h3C, 8'hBA, 8'h0F, 8'h19, 8'h23};
      run_layer(1'b0, 1'b1, -1, 5, 8'h3C);
      foreach (lat[i]) lat[i] = 1;
      res = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h10, 8'h20, 8'h30};
      run_layer(1'b1, 1'b0, 4, 0, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      check_cleared("midrst");
      rst = 1'b1;
      d = 0;
      repeat (5) begin
         @(negedge clk);
         d += int'(bus.done) + int'(bus.busy);
      end
      check("no_done_after_rst", d, 0);
      res = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hF7};
      run_layer(1'b1, 1'b0, -1, 8, 8'h08);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
